// File: rtl/iter_divider_5bit_pkg.sv
// Shared constants and state encoding for the 5-bit iterative restoring divider.
package iter_divider_5bit_pkg;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 3;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FA_5bit.sv
// 5-bit adder with carry in/out; used by the divider as its trial subtractor.
module FA_5bit (
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       cin,
  output logic [4:0] Sum,
  output logic       Cout
);

  logic [5:0] carry;

  assign carry[0] = cin;

  // Ripple chain of full adders.
  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  assign Cout = carry[5];

endmodule

// File: rtl/iter_divider_5bit.sv
// Unsigned 5-bit restoring divider: one quotient bit per clock behind a start/done handshake.
module iter_divider_5bit
  import iter_divider_5bit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic             dbz_d;

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] fa_sum;
  logic             fa_cout;
  logic             trial_ok;
  logic [WIDTH-1:0] trial_r;
  logic [WIDTH-1:0] trial_q;

  // Shift {R,Q} left; the bit leaving R is kept as rs[WIDTH].
  assign rs = {r_q, q_q[WIDTH-1]};

  FA_5bit u_sub (
    .A    (rs[WIDTH-1:0]),
    .B    (~d_q),
    .cin  (1'b1),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // No borrow, or the shifted-out bit guarantees Rs >= D.
  assign trial_ok = fa_cout | rs[WIDTH];
  assign trial_r  = trial_ok ? fa_sum : rs[WIDTH-1:0];
  assign trial_q  = {q_q[WIDTH-2:0], trial_ok};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;

    case (state_q)
      IDLE: begin
        if (start) begin
          d_d   = divisor;
          r_d   = '0;
          q_d   = dividend;
          cnt_d = '0;
          if (divisor != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            quo_d   = DIV0_QUOTIENT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = trial_r;
        q_d   = trial_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quo_d   = trial_q;
          rem_d   = trial_r;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with RUN/DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient    <= quo_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
      busy        <= (state_d == RUN);
      done        <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_iter_divider_5bit.sv
// Self-checking bench for iter_divider_5bit: transaction-level model plus directed and random operations.
module tb_iter_divider_5bit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [4:0] dividend;
  logic [4:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  iter_divider_5bit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Transaction-level model: cycles-to-done countdown and results from / and %.
  int         m_left = 0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [4:0] m_q = '0;
  logic [4:0] m_r = '0;
  bit         m_dbz = 1'b0;
  logic [4:0] p_q = '0;
  logic [4:0] p_r = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_left = 0; m_busy = 0; m_done = 0; m_q = '0; m_r = '0; m_dbz = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 0;
      end
    end else if (start) begin
      if (divisor == 5'd0) begin
        m_done = 1; m_q = 5'd31; m_r = dividend; m_dbz = 1;
      end else begin
        m_busy = 1; m_left = 5;
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("quotient", 32'(quotient), 32'(m_q));
      check("remainder", 32'(remainder), 32'(m_r));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      if (done === 1'b1) n_done++;
    end
  end

  // Caller is at a negedge with the DUT idle; returns edges from accept to done.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b, input bit noise, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 5'($urandom);
        divisor  = 5'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (lat >= 20) check("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_result(input string name, input int q, input int r, input int dbz);
    check({name, "_q"}, 32'(quotient), 32'(q));
    check({name, "_r"}, 32'(remainder), 32'(r));
    check({name, "_dbz"}, 32'(div_by_zero), 32'(dbz));
    check({name, "_model_q"}, 32'(m_q), 32'(q));
  endtask

  initial begin
    int lat;
    int nd0;
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(5'd27, 5'd5, 1'b0, lat);
    check("lat_27_5", 32'(lat), 32'd5);
    check_result("d27_5", 5, 2, 0);
    run_op(5'd31, 5'd1, 1'b0, lat);
    check("lat_31_1", 32'(lat), 32'd5);
    check_result("d31_1", 31, 0, 0);
    run_op(5'd3, 5'd7, 1'b0, lat);
    check_result("d3_7", 0, 3, 0);
    run_op(5'd0, 5'd9, 1'b0, lat);
    check("lat_0_9", 32'(lat), 32'd5);
    check_result("d0_9", 0, 0, 0);
    run_op(5'd9, 5'd0, 1'b0, lat);
    check("lat_div0", 32'(lat), 32'd0);
    check_result("d9_0", 31, 9, 1);
    run_op(5'd20, 5'd6, 1'b0, lat);
    check_result("d20_6", 3, 2, 0);

    // Start pulse and operand changes during RUN must be ignored.
    nd0 = n_done;
    start = 1'b1; dividend = 5'd27; divisor = 5'd5;
    @(negedge clk);
    dividend = 5'd10; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0; dividend = 5'd7; divisor = 5'd2;
    repeat (8) @(negedge clk);
    check("overrun_done_count", 32'(n_done - nd0), 32'd1);
    check_result("overrun", 5, 2, 0);
    run_op(5'd10, 5'd3, 1'b0, lat);
    check_result("d10_3", 3, 1, 0);

    // Reset at the third RUN cycle discards the operation.
    nd0 = n_done;
    start = 1'b1; dividend = 5'd30; divisor = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check_result("midrst", 0, 0, 0);
    repeat (8) @(negedge clk);
    check("midrst_no_done", 32'(n_done - nd0), 32'd0);
    run_op(5'd30, 5'd4, 1'b0, lat);
    check_result("d30_4", 7, 2, 0);

    // Start coincident with reset is not accepted.
    reset_n = 1'b0; start = 1'b1; dividend = 5'd12; divisor = 5'd0;
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rststart_done", 32'(done), 32'd0);
    check("rststart_busy", 32'(busy), 32'd0);

    // Exhaustive sweep with occasional input noise while busy.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        run_op(5'(a), 5'(b), ($urandom_range(0, 3) == 0), lat);
        check("sweep_lat", 32'(lat), (b == 0) ? 32'd0 : 32'd5);
        if (b == 0) begin
          check("sweep_q0", 32'(quotient), 32'd31);
          check("sweep_r0", 32'(remainder), 32'(a));
        end else begin
          check("sweep_q", 32'(quotient), 32'(a / b));
          check("sweep_r", 32'(remainder), 32'(a % b));
        end
      end
    end

    // Random operations with random idle gaps.
    for (int i = 0; i < 200; i++) begin
      run_op(5'($urandom), 5'($urandom), 1'b1, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
